// File: rtl/lu_recompose_2x2.sv
// -----------------------------------------------------------------------------
// lu_recompose_2x2
//
// Rebuilds A = L*U from the packed 2x2 factors produced by the LU decomposer.
// The block uses one multiplier and an accumulator. It runs eight MAC steps,
// two per output element, in the fixed order a00, a01, a10, a11.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   L          {l00,l01,l10,l11}, l00 in the MSBs, W bits each
//   U          {u00,u01,u10,u11}, u00 in the MSBs, W bits each
//   in_valid   L/U valid this cycle
//   in_ready   block is idle and can accept an operand pair (combinational)
//   A          {a00,a01,a10,a11}, a00 in the MSBs, OW = 2W+1 bits each
//   out_valid  A holds a complete result (registered)
//   out_ready  downstream accepts A
//   busy       high while the MAC sequence runs (registered)
//
// Configuration:
//   LU_RECOMP_SIGNED_EN  When defined, L/U elements are two's complement.
//                        Products and sums are signed, and A elements are
//                        sign-extended. When undefined, all operands are
//                        unsigned.
// -----------------------------------------------------------------------------
module lu_recompose_2x2 #(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4*W-1:0]       L,
  input  logic [4*W-1:0]       U,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [4*(2*W+1)-1:0] A,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int OW = 2*W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [2:0]      step_q;
  logic [4*W-1:0]  l_q;
  logic [4*W-1:0]  u_q;
  logic [OW-1:0]   acc_q;
  logic [OW-1:0]   a_q [4];
  logic            out_valid_q;
  logic            busy_q;

  // Unpack the captured factors and pack the result, index 0 = MSB element.
  logic [W-1:0] l_el [4];
  logic [W-1:0] u_el [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pack
      assign l_el[gi]                  = l_q[(3-gi)*W +: W];
      assign u_el[gi]                  = u_q[(3-gi)*W +: W];
      assign A[(3-gi)*OW +: OW]        = a_q[gi];
    end
  endgenerate

  // Step decode: element e = s[2:1] -> (i,j) = (e[1], e[0]), inner index k = s[0].
  logic [1:0] elem;
  logic [1:0] l_idx;
  logic [1:0] u_idx;
  assign elem  = step_q[2:1];
  assign l_idx = {elem[1], step_q[0]};   // l_ik
  assign u_idx = {step_q[0], elem[0]};   // u_kj

  logic [W-1:0]   l_sel;
  logic [W-1:0]   u_sel;
  logic [2*W-1:0] prod;
  logic [OW-1:0]  prod_ext;
  logic [OW-1:0]  sum_d;

  assign l_sel = l_el[l_idx];
  assign u_sel = u_el[u_idx];

`ifdef LU_RECOMP_SIGNED_EN
  // The low 2W bits of the product of sign-extended operands are the exact
  // signed product. (-2^(W-1))^2 still fits in 2W bits as a signed value.
  assign prod     = $signed({{W{l_sel[W-1]}}, l_sel}) * $signed({{W{u_sel[W-1]}}, u_sel});
  assign prod_ext = {prod[2*W-1], prod};
`else
  assign prod     = {{W{1'b0}}, l_sel} * {{W{1'b0}}, u_sel};
  assign prod_ext = {1'b0, prod};
`endif

  // The sum of two products needs one extra bit, and OW provides it.
  assign sum_d = acc_q + prod_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= '0;
      l_q         <= '0;
      u_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int n = 0; n < 4; n++) a_q[n] <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            l_q     <= L;
            u_q     <= U;
            step_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= MAC;
          end
        end
        MAC: begin
          if (!step_q[0]) acc_q       <= prod_ext;
          else            a_q[elem]   <= sum_d;
          if (step_q == 3'd7) begin
            step_q      <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            step_q <= step_q + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lu_recompose_2x2.sv
// -----------------------------------------------------------------------------
// tb_lu_recompose_2x2
//
// Self-checking bench for lu_recompose_2x2 with W = 8.
// It applies a table of directed vectors, hand-written sequences for the
// stall, mid-run reset and back-to-back corner cases, and randomized
// transactions. All of these are checked against a plain matrix-product
// reference model.
// -----------------------------------------------------------------------------
module tb_lu_recompose_2x2;

  localparam int W  = 8;
  localparam int OW = 2*W + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [4*W-1:0]  L;
  logic [4*W-1:0]  U;
  logic            in_valid;
  logic            in_ready;
  logic [4*OW-1:0] A;
  logic            out_valid;
  logic            out_ready;
  logic            busy;

  int tests = 0;
  int fails = 0;

  lu_recompose_2x2 #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .L         (L),
    .U         (U),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model: ordinary 2x2 matrix product on integers.
  // ---------------------------------------------------------------------------
  function automatic int elem_val(input logic [31:0] m, input int idx);
    logic [7:0] b;
    int v;
    b = m[(3-idx)*8 +: 8];
`ifdef LU_RECOMP_SIGNED_EN
    v = int'($signed(b));
`else
    v = int'({24'd0, b});
`endif
    return v;
  endfunction

  function automatic logic [67:0] ref_a(input logic [31:0] lm, input logic [31:0] um);
    logic [67:0] r;
    int acc;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        acc = 0;
        for (int k = 0; k < 2; k++)
          acc += elem_val(lm, i*2+k) * elem_val(um, k*2+j);
        r[(3-(i*2+j))*17 +: 17] = acc[16:0];
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // The caller must be sitting 1 time unit after a rising edge.
  task automatic wait_out_valid(input string name, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " latency"}, 68'(cyc), 68'd8);
  endtask

  // Runs one full transaction with the output stalled for `stall` cycles.
  task automatic run_txn(input logic [31:0] lm, input logic [31:0] um,
                         input logic [67:0] exp, input string name, input int stall);
    int cyc;
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    L = lm; U = um; in_valid = 1'b1; out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    L = $urandom; U = $urandom;           // changes after capture must not matter
    check({name, " busy"}, 68'(busy), 68'd1);
    wait_out_valid(name, cyc);
    check({name, " A"}, A, exp);
    if (stall > 0) begin
      repeat (stall) begin @(posedge clk); #1; end
      check({name, " held A"}, A, exp);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({name, " ready after"}, {66'd0, out_valid, in_ready}, 68'b01);
    $display("[TB] txn %s L=%h U=%h A=%h latency=%0d stall=%0d", name, lm, um, A, cyc, stall);
  endtask

  typedef struct {
    logic [31:0] l;
    logic [31:0] u;
    logic [67:0] exp_u;
    logic [67:0] exp_s;
    string       name;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [67:0] e;
    logic [67:0] e1;
    logic [67:0] e2;
    logic [31:0] l2;
    logic [31:0] u2;
    int cyc;
    int cnt;
    int last;
    int got;
    int pushed;
    logic [67:0] exp_q [$];

    tbl[0] = '{32'h01000201, 32'h03040005, {17'd3, 17'd4, 17'd6, 17'd13},
               {17'd3, 17'd4, 17'd6, 17'd13}, "basic"};
    tbl[1] = '{32'h01000501, 32'h010200FA, {17'd1, 17'd2, 17'd5, 17'd260},
               {17'd1, 17'd2, 17'd5, 17'd4}, "decomp"};
    tbl[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, {4{17'h1FC02}}, {4{17'd2}}, "all_ff"};
    tbl[3] = '{32'h80808080, 32'h80808080, {4{17'd32768}}, {4{17'd32768}}, "all_80"};
    tbl[4] = '{32'h00000000, 32'h00000000, 68'd0, 68'd0, "zeros"};

    // Reset: in_valid is ignored, and in_ready reads 1 because the state is IDLE.
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    L = 32'h12345678; U = 32'h9ABCDEF0;
    @(posedge clk); #1;
    check("reset outputs", {in_ready, out_valid, busy, A[64:0]}, {3'b100, 65'd0});
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post reset idle", {66'd0, busy, in_ready}, 68'b01);
    check("post reset A", A, 68'd0);

    // Directed table.
    for (int t = 0; t < 5; t++) begin
`ifdef LU_RECOMP_SIGNED_EN
      e = tbl[t].exp_s;
`else
      e = tbl[t].exp_u;
`endif
      run_txn(tbl[t].l, tbl[t].u, e, tbl[t].name, 0);
    end

    // Output stall: A holds, and an in_valid during DONE is not accepted.
    e1 = ref_a(32'h01000201, 32'h03040005);
    l2 = 32'h02030405; u2 = 32'h06070809;
    e2 = ref_a(l2, u2);
    L = 32'h01000201; U = 32'h03040005; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out_valid("stall", cyc);
    check("stall A", A, e1);
    L = l2; U = u2; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("stall hold", {A, out_valid, in_ready, busy} >> 3, e1);
      check("stall flags", {65'd0, out_valid, in_ready, busy}, 68'b100);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall release", {65'd0, out_valid, in_ready, busy}, 68'b010);
    @(posedge clk); #1;
    check("stall next accept", 68'(busy), 68'd1);
    in_valid = 1'b0;
    wait_out_valid("stall second", cyc);
    check("stall second A", A, e2);
    @(posedge clk); #1;
    $display("[TB] txn stall L=%h U=%h A=%h", l2, u2, e2);

    // Asynchronous reset at MAC step 3. At that point a00 has been rewritten,
    // and a01..a11 still hold the previous result.
    L = 32'h01000201; U = 32'h03040005; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid MAC partial A", A, {e1[67:51], e2[50:0]});
    rst_n = 1'b0;
    in_valid = 1'b1;
    #1;
    check("async reset", {in_ready, out_valid, busy, A[64:0]}, {3'b100, 65'd0});
    check("async reset A", A, 68'd0);
    @(posedge clk); @(posedge clk); #2;
    check("reset ignores in_valid", 68'(busy), 68'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset release idle", 68'(in_ready), 68'd1);
    run_txn(32'h01000501, 32'h010200FA, ref_a(32'h01000501, 32'h010200FA), "after_reset", 0);

    // Back to back: in_valid stays high and out_ready stays high, so there is
    // one result every 10 cycles.
    out_ready = 1'b1;
    L = $urandom; U = $urandom; in_valid = 1'b1;
    cnt = 0; last = -1; got = 0; pushed = 0;
    while (got < 5 && cnt < 200) begin
      logic accepting;
      accepting = in_ready && in_valid;
      if (accepting) begin
        exp_q.push_back(ref_a(L, U));
        pushed++;
      end
      @(posedge clk); #1;
      cnt++;
      if (accepting) begin
        if (pushed >= 5) in_valid = 1'b0;
        else begin L = $urandom; U = $urandom; end
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL b2b: out_valid with no accepted operand, A=%h", A);
        end else begin
          e = exp_q.pop_front();
          check("b2b A", A, e);
          $display("[TB] txn b2b A=%h at cycle %0d", A, cnt);
        end
        if (last >= 0) check("b2b interval", 68'(cnt - last), 68'd10);
        last = cnt;
        got++;
      end
    end
    check("b2b count", 68'(got), 68'd5);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Randomized transactions with random output stalls.
    for (int r = 0; r < 20; r++) begin
      logic [31:0] rl;
      logic [31:0] ru;
      rl = $urandom; ru = $urandom;
      run_txn(rl, ru, ref_a(rl, ru), "rand", $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
